memctrl_host: RTL and testbench

MEMCTRL_HOST -- requirements
Module: memctrl_host

---
 rtl/memctrl_host_pkg.sv | 18 +
 rtl/memctrl_host_phase_cnt.sv | 39 +++
 rtl/memctrl_host.sv | 168 ++++++++++++++++
 tb/tb_memctrl_host.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_host_pkg.sv
// Shared types and constants for the memory-controller host sequencer.
package memctrl_host_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int CNT_W       = 4;
    localparam int CE_HALF_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CE1H  = 3'd2,
        CE1L  = 3'd3,
        CE2H  = 3'd4,
        CE2L  = 3'd5
    } state_e;

endpackage

// File: rtl/memctrl_host_phase_cnt.sv
// Loadable down-counter timing each CE half-phase; flags terminal count now and next cycle.
module memctrl_host_phase_cnt
    import memctrl_host_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc,
    output logic             tc_nxt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, decrement, or park at zero.
    always_comb begin
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc     = (cnt_q == {CNT_W{1'b0}});
    assign tc_nxt = (cnt_d == {CNT_W{1'b0}});

endmodule

// File: rtl/memctrl_host.sv
// Host-side sequencer: turns one request into a two-CE-pulse memory-controller cycle.
module memctrl_host
    import memctrl_host_pkg::*;
#(
    parameter int CE_HALF = CE_HALF_DEF
)
(
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              CSB,
    output logic              WEB,
    output logic              OEB,
    output logic              CE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] IDATA,
    input  logic [DATA_W-1:0] ODATA
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              rsp_q, rsp_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic              oeb_q, oeb_d;
    logic              ce_q, ce_d;
    logic              tc_s;
    logic              tc_nxt_s;
    logic              load_s;

    assign load_s = (state_d != state_q);

    memctrl_host_phase_cnt u_phase_cnt (
        .clk      (CLK),
        .rst_n    (RSTN),
        .load     (load_s),
        .load_val (CNT_W'(CE_HALF - 1)),
        .tc       (tc_s),
        .tc_nxt   (tc_nxt_s)
    );

    // Next-state, request capture and read-data capture on the CE1L exit edge.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (REQ_VALID && ready_q) begin
                    state_d = SETUP;
                    we_d    = REQ_WE;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: state_d = CE1H;
            CE1H: begin
                if (tc_s) begin
                    state_d = CE1L;
                end else begin
                    state_d = CE1H;
                end
            end
            CE1L: begin
                if (tc_s) begin
                    state_d = CE2H;
                    if (!we_q) begin
                        rdata_d = ODATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = CE1L;
                end
            end
            CE2H: begin
                if (tc_s) begin
                    state_d = CE2L;
                end else begin
                    state_d = CE2H;
                end
            end
            CE2L: begin
                if (tc_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = CE2L;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every pin comes straight from a flop.
    always_comb begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        oeb_d   = 1'b1;
        ce_d    = 1'b0;
        ready_d = (state_d == IDLE);
        rsp_d   = (state_d == CE2L) && tc_nxt_s;
        case (state_d)
            SETUP, CE1H: begin
                csb_d = 1'b0;
                web_d = ~we_d;
                oeb_d = we_d;
                ce_d  = (state_d == CE1H);
            end
            CE1L:    oeb_d = we_d;
            CE2H:    ce_d  = 1'b1;
            default: ce_d  = 1'b0;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            ready_q <= 1'b0;
            rsp_q   <= 1'b0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            oeb_q   <= 1'b1;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            rsp_q   <= rsp_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            oeb_q   <= oeb_d;
            ce_q    <= ce_d;
        end
    end

    assign REQ_READY = ready_q;
    assign RSP_VALID = rsp_q;
    assign RSP_RDATA = rdata_q;
    assign CSB       = csb_q;
    assign WEB       = web_q;
    assign OEB       = oeb_q;
    assign CE        = ce_q;
    assign ADDR      = addr_q;
    assign IDATA     = wdata_q;

endmodule

// File: tb/tb_memctrl_host.sv
// Directed bench for memctrl_host at CE_HALF=1 and CE_HALF=3 with a response scoreboard.
module tb_memctrl_host;

    typedef struct {
        logic [7:0] rdata;
    } sb_t;

    logic        CLK;
    logic        RSTN;
    logic        valid1, valid3;
    logic        REQ_WE;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic [7:0]  ODATA;

    logic        ready1, rsp1, csb1, web1, oeb1, ce1;
    logic [7:0]  rdata1, idata1;
    logic [15:0] addr1;
    logic        ready3, rsp3, csb3, web3, oeb3, ce3;
    logic [7:0]  rdata3, idata3;
    logic [15:0] addr3;

    logic        sel;
    logic [5:0]  ctl_obs;
    logic [23:0] bus_obs;
    logic [7:0]  rdata_obs;
    logic        rsp_obs;
    logic        ready_obs;

    int          checks;
    int          errors;
    sb_t         sb[$];
    logic [7:0]  last_rd [2];

    memctrl_host #(.CE_HALF(1)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .REQ_VALID(valid1), .REQ_READY(ready1),
        .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(rsp1), .RSP_RDATA(rdata1), .CSB(csb1), .WEB(web1),
        .OEB(oeb1), .CE(ce1), .ADDR(addr1), .IDATA(idata1), .ODATA(ODATA)
    );

    memctrl_host #(.CE_HALF(3)) dut3 (
        .CLK(CLK), .RSTN(RSTN), .REQ_VALID(valid3), .REQ_READY(ready3),
        .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(rsp3), .RSP_RDATA(rdata3), .CSB(csb3), .WEB(web3),
        .OEB(oeb3), .CE(ce3), .ADDR(addr3), .IDATA(idata3), .ODATA(ODATA)
    );

    assign ctl_obs   = sel ? {ready3, csb3, web3, oeb3, ce3, rsp3}
                           : {ready1, csb1, web1, oeb1, ce1, rsp1};
    assign bus_obs   = sel ? {addr3, idata3} : {addr1, idata1};
    assign rdata_obs = sel ? rdata3 : rdata1;
    assign rsp_obs   = sel ? rsp3 : rsp1;
    assign ready_obs = sel ? ready3 : ready1;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the selected instance, checked cycle by cycle against the phase model.
    task automatic run_txn(input bit s, input bit we, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] od, input bit hold, input bit exp_gap, input int abort_k);
        int h, waits, last_k, ph;
        bit lastp, first, oe_win;
        logic [5:0] exp_ctl;
        logic [7:0] exp_rd;
        sb_t e;
        h         = s ? 3 : 1;
        sel       = s;
        REQ_WE    = we;
        REQ_ADDR  = a;
        REQ_WDATA = wd;
        ODATA     = ~od;
        if (s) valid3 = 1'b1; else valid1 = 1'b1;
        waits = 0;
        while (!ready_obs && waits < 20) begin
            @(negedge CLK);
            waits++;
        end
        chk("accept_ready", ready_obs, 1);
        if (exp_gap) chk("idle_gap", waits, 1);
        e.rdata = we ? last_rd[s] : od;
        sb.push_back(e);
        last_k = 1 + 4 * h;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                ph    = -1;
                lastp = 1'b0;
            end else begin
                ph    = (k - 2) / h;
                lastp = ((k - 2) % h) == (h - 1);
            end
            first   = (k == 1) || (ph == 0);
            oe_win  = (k == 1) || (ph == 0) || (ph == 1);
            exp_ctl = {1'b0, !first, !(first && we), !(oe_win && !we),
                       (ph == 0) || (ph == 2), (ph == 3) && lastp};
            exp_rd  = (!we && k >= 2 + 2 * h) ? od : last_rd[s];
            chk("ctl", ctl_obs, exp_ctl);
            chk("bus", bus_obs, {a, wd});
            chk("rdata", rdata_obs, exp_rd);
            if (rsp_obs) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_obs, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rdata_obs, e.rdata);
                    chk("latency", k, last_k);
                end
            end
            if (k == 1 && !hold) begin
                valid1 = 1'b0;
                valid3 = 1'b0;
            end
            if (k == 2) begin
                REQ_ADDR  = 16'($urandom);
                REQ_WDATA = 8'($urandom);
                REQ_WE    = 1'($urandom);
            end
            ODATA = (k == 1 + 2 * h) ? od : ~od;
            if (k == abort_k) begin
                #1 RSTN = 1'b0;
                #1;
                chk("rst_ctl", ctl_obs, 6'b011100);
                chk("rst_bus", bus_obs, 24'h000000);
                chk("rst_rdata", rdata_obs, 8'h00);
                sb.delete();
                valid1     = 1'b0;
                valid3     = 1'b0;
                last_rd[0] = 8'h00;
                last_rd[1] = 8'h00;
                return;
            end
        end
        if (!we) last_rd[s] = od;
        if (!hold) begin
            @(negedge CLK);
            chk("idle_ctl", ctl_obs, 6'b111100);
            chk("idle_bus", bus_obs, {a, wd});
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        sel        = 1'b0;
        RSTN       = 1'b0;
        valid1     = 1'b0;
        valid3     = 1'b0;
        REQ_WE     = 1'b0;
        REQ_ADDR   = 16'h0000;
        REQ_WDATA  = 8'h00;
        ODATA      = 8'h00;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            chk("reset_ctl", ctl_obs, 6'b011100);
            chk("reset_bus", bus_obs, 24'h000000);
            chk("reset_rdata", rdata_obs, 8'h00);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        #1 chk("release_ready_low", ctl_obs, 6'b011100);
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1 chk("release_ready_high", ctl_obs, 6'b111100);
        end

        // CE_HALF=1 write then read of the same location
        run_txn(1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 1'b0, 0);

        // CE_HALF=3 read
        run_txn(1'b1, 1'b0, 16'hBEEF, 8'h11, 8'h3C, 1'b0, 1'b0, 0);

        // REQ_VALID held across three writes
        run_txn(1'b0, 1'b1, 16'h1000, 8'h11, 8'h00, 1'b1, 1'b0, 0);
        run_txn(1'b0, 1'b1, 16'h2000, 8'h22, 8'h00, 1'b1, 1'b1, 0);
        run_txn(1'b0, 1'b1, 16'h3000, 8'h33, 8'h00, 1'b0, 1'b1, 0);

        // Reset during CE2H of a read (cycle 4 after accept at CE_HALF=1)
        run_txn(1'b0, 1'b0, 16'h4242, 8'h00, 8'h77, 1'b0, 1'b0, 4);
        repeat (2) begin
            @(negedge CLK);
            chk("abort_hold_ctl", ctl_obs, 6'b011100);
        end
        RSTN = 1'b1;
        #1 chk("abort_release_ctl", ctl_obs, 6'b011100);
        repeat (2) begin
            @(negedge CLK);
            chk("abort_recover_ctl", ctl_obs, 6'b111100);
            chk("abort_rdata", rdata_obs, 8'h00);
        end

        // Address extremes
        run_txn(1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 1'b0, 0);

        // CE_HALF=3 write must leave read data untouched
        run_txn(1'b1, 1'b1, 16'h00AA, 8'h5A, 8'h99, 1'b0, 1'b0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
